// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO, with sticky framing/overrun flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and a sticky parity_error output.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          uart_rx_input,
   input  logic                          rd_en,
   output logic [7:0]                    rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_error,
   output logic                          overrun_error,
`ifdef UART_RX_PARITY_EN
   output logic                          parity_error,
`endif
   input  logic                          err_clear
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_MID    = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t          state_reg, state_next;
   logic            sync1_reg, rx_s_reg, rx_prev_reg;
   logic [CW-1:0]   cnt_reg;
   logic [2:0]      idx_reg;
   logic [7:0]      shift_reg;
   logic            bit_end, cnt_clr;
   logic            shift_en, push_req, frame_set;
`ifdef UART_RX_PARITY_EN
   logic            parity_bad_reg, parity_set;
`endif

   assign bit_end = (cnt_reg == CNT_LAST);
   assign cnt_clr = (state_next != state_reg) || bit_end ||
                    (state_reg == S_IDLE) || (state_reg == S_WAIT_IDLE);

   always_ff @(posedge clock) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:      if (rx_prev_reg && !rx_s_reg) state_next = S_START;
         S_START:     if (cnt_reg == CNT_MID) state_next = rx_s_reg ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
         S_DATA:      if (bit_end && idx_reg == 3'd7) state_next = S_PARITY;
         S_PARITY:    if (bit_end) state_next = S_STOP;
`else
         S_DATA:      if (bit_end && idx_reg == 3'd7) state_next = S_STOP;
`endif
         S_STOP:      if (bit_end) state_next = rx_s_reg ? S_IDLE : S_WAIT_IDLE;
         S_WAIT_IDLE: if (rx_s_reg) state_next = S_IDLE;
         default:     state_next = S_IDLE;
      endcase
   end

   always_comb begin
      shift_en  = 1'b0;
      push_req  = 1'b0;
      frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_set = 1'b0;
`endif
      case (state_reg)
         S_DATA: shift_en = bit_end;
`ifdef UART_RX_PARITY_EN
         S_PARITY: parity_set = bit_end && (rx_s_reg != ^shift_reg);
         S_STOP: begin
            push_req  = bit_end && rx_s_reg && !parity_bad_reg;
            frame_set = bit_end && !rx_s_reg;
         end
`else
         S_STOP: begin
            push_req  = bit_end && rx_s_reg;
            frame_set = bit_end && !rx_s_reg;
         end
`endif
         default: ;
      endcase
   end

   // Synchroniser and edge register preset high so reset never looks like a start edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_reg   <= 1'b1;
         rx_s_reg    <= 1'b1;
         rx_prev_reg <= 1'b1;
         cnt_reg     <= '0;
         idx_reg     <= '0;
         shift_reg   <= '0;
      end else begin
         sync1_reg   <= uart_rx_input;
         rx_s_reg    <= sync1_reg;
         rx_prev_reg <= rx_s_reg;
         cnt_reg     <= cnt_clr ? '0 : cnt_reg + 1'b1;
         if (state_reg == S_START) begin
            idx_reg <= '0;
         end else if (shift_en) begin
            shift_reg <= {rx_s_reg, shift_reg[7:1]};
            idx_reg   <= idx_reg + 1'b1;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clock) begin
      if (reset)                    parity_bad_reg <= 1'b0;
      else if (state_reg == S_START) parity_bad_reg <= 1'b0;
      else if (parity_set)          parity_bad_reg <= 1'b1;
   end
`endif

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0] count_reg;
   logic        pop, do_push, overrun_set;

   assign pop         = rd_en && (count_reg != '0);
   // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
   assign do_push     = push_req && ((count_reg != FULL_COUNT) || pop);
   assign overrun_set = push_req && (count_reg == FULL_COUNT) && !pop;

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr_reg] <= shift_reg;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign rd_valid   = (count_reg != '0);
   assign rd_data    = rd_valid ? mem[rd_ptr_reg] : 8'h00;
   assign fifo_count = count_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         frame_error   <= 1'b0;
         overrun_error <= 1'b0;
      end else begin
         frame_error   <= frame_set   ? 1'b1 : (err_clear ? 1'b0 : frame_error);
         overrun_error <= overrun_set ? 1'b1 : (err_clear ? 1'b0 : overrun_error);
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clock) begin
      if (reset) parity_error <= 1'b0;
      else       parity_error <= parity_set ? 1'b1 : (err_clear ? 1'b0 : parity_error);
   end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven bit by bit, FIFO contents and
// sticky flags compared against a byte-queue reference model.
module tb_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int STOP_IDX = NBITS - 1;
   // Cycle after which a received byte becomes visible: two synchroniser flops and the
   // edge register, half a bit to mid-start, then one bit period per bit up to mid-stop.
   localparam int PUSH_VIS = 3 + CPB / 2 + (NBITS - 1) * CPB;
   localparam int FRAME_CYC = NBITS * CPB;

   logic       clock, reset, uart_rx_input, rd_en, err_clear;
   logic [7:0] rd_data;
   logic       rd_valid, frame_error, overrun_error;
   logic [3:0] fifo_count;
`ifdef UART_RX_PARITY_EN
   logic       parity_error;
`endif

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock),
      .reset(reset),
      .uart_rx_input(uart_rx_input),
      .rd_en(rd_en),
      .rd_data(rd_data),
      .rd_valid(rd_valid),
      .fifo_count(fifo_count),
      .frame_error(frame_error),
      .overrun_error(overrun_error),
`ifdef UART_RX_PARITY_EN
      .parity_error(parity_error),
`endif
      .err_clear(err_clear)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] model_q[$];
   bit         m_frame, m_overrun, m_parity;
   bit         vhist [FRAME_CYC];
   logic [7:0] popped;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Drives one serial frame; optionally pulses rd_en for the edge after pop_cyc.
   task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_flip,
                             input int pop_cyc, input int max_cyc);
      logic [NBITS-1:0] frame;
      frame = '0;
      frame[8:1] = b;
`ifdef UART_RX_PARITY_EN
      frame[9] = (^b) ^ par_flip;
`else
      if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
      frame[STOP_IDX] = stop_bit;
      for (int cyc = 0; cyc < FRAME_CYC && cyc < max_cyc; cyc++) begin
         @(posedge clock);
         #1;
         vhist[cyc] = rd_valid;
         if (cyc == pop_cyc) begin
            popped = rd_data;
            rd_en  = 1'b1;
         end else begin
            rd_en = 1'b0;
         end
         uart_rx_input = frame[cyc / CPB];
      end
      rd_en = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit stop_bit, input bit par_flip,
                              input bit popping);
      if (popping && model_q.size() != 0) void'(model_q.pop_front());
      if (par_flip) m_parity = 1'b1;
      if (!stop_bit) m_frame = 1'b1;
      else if (!par_flip) begin
         if (model_q.size() < DEPTH) model_q.push_back(b);
         else                        m_overrun = 1'b1;
      end
   endtask

   task automatic rx_byte(input logic [7:0] b);
      send_frame(b, 1'b1, 1'b0, -1, FRAME_CYC);
      model_frame(b, 1'b1, 1'b0, 1'b0);
      $display("rx byte 0x%02h -> model depth %0d", b, model_q.size());
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] exp;
      if (model_q.size() == 0) begin
         check({tag, "_empty_valid"}, rd_valid, 0);
      end else begin
         exp = model_q[0];
         check({tag, "_valid"}, rd_valid, 1);
         check({tag, "_data"}, rd_data, exp);
         $display("pop %s got 0x%02h want 0x%02h", tag, rd_data, exp);
         rd_en = 1'b1;
         tick(1);
         rd_en = 1'b0;
         void'(model_q.pop_front());
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_count"}, fifo_count, model_q.size());
      check({tag, "_valid"}, rd_valid, model_q.size() != 0);
      check({tag, "_ferr"}, frame_error, m_frame);
      check({tag, "_oerr"}, overrun_error, m_overrun);
`ifdef UART_RX_PARITY_EN
      check({tag, "_perr"}, parity_error, m_parity);
`endif
   endtask

   task automatic clear_errors();
      err_clear = 1'b1;
      tick(1);
      err_clear = 1'b0;
      m_frame = 1'b0;
      m_overrun = 1'b0;
      m_parity = 1'b0;
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] head;
      int         glen;

      uart_rx_input = 1'b1;
      rd_en = 1'b0;
      err_clear = 1'b0;
      reset = 1'b1;
      m_frame = 1'b0;
      m_overrun = 1'b0;
      m_parity = 1'b0;

      // Reset state
      tick(2);
      reset = 1'b0;
      check("rst_valid", rd_valid, 0);
      check("rst_count", fifo_count, 0);
      check("rst_data", rd_data, 0);
      check("rst_ferr", frame_error, 0);
      check("rst_oerr", overrun_error, 0);
      tick(4);

      // Single byte with push latency
      send_frame(8'hA5, 1'b1, 1'b0, -1, FRAME_CYC);
      model_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      check("lat_before", vhist[PUSH_VIS-1], 0);
      check("lat_at", vhist[PUSH_VIS], 1);
      check("a5_data", rd_data, 8'hA5);
      check_state("a5");
      pop_check("a5_pop");
      check("a5_after_count", fifo_count, 0);
      check("a5_after_valid", rd_valid, 0);

      // Back-to-back frames, no pops
      rx_byte(8'h00);
      rx_byte(8'hFF);
      rx_byte(8'h5A);
      rx_byte(8'h3C);
      check("b2b_count", fifo_count, 4);
      repeat (4) pop_check("b2b_pop");

      // Pointer wrap with random payloads
      repeat (2) begin
         repeat (6) rx_byte(8'($urandom_range(0, 255)));
         check_state("wrap");
         repeat (6) pop_check("wrap_pop");
      end
      check_state("wrap_end");

      // Overrun: fill, then one more with no pop
      for (int i = 1; i <= 8; i++) rx_byte(8'(i));
      rx_byte(8'h09);
      check_state("ovr");
      check("ovr_head", rd_data, 8'h01);
      clear_errors();
      check_state("ovr_clr");

      // Full FIFO with pop on the push edge: accepted, no overrun
      head = model_q[0];
      send_frame(8'h09, 1'b1, 1'b0, PUSH_VIS - 1, FRAME_CYC);
      model_frame(8'h09, 1'b1, 1'b0, 1'b1);
      check("pp_popped", popped, head);
      check_state("pp");
      while (model_q.size() != 0) pop_check("pp_drain");
      check_state("pp_empty");

      // Bad stop bit followed by a 40-bit-time break
      send_frame(8'h55, 1'b0, 1'b0, -1, FRAME_CYC);
      model_frame(8'h55, 1'b0, 1'b0, 1'b0);
      tick(CPB);
      check_state("ferr");
      clear_errors();
      tick(39 * CPB);
      check_state("break_single");
      uart_rx_input = 1'b1;
      tick(2 * CPB);
      rx_byte(8'h33);
      check_state("after_break");
      pop_check("b33_pop");

      // Short glitch on an idle line
      glen = $urandom_range(1, 5);
      uart_rx_input = 1'b0;
      tick(glen);
      uart_rx_input = 1'b1;
      tick(3 * CPB);
      check_state("glitch");
      b = 8'($urandom_range(0, 255));
      rx_byte(b);
      pop_check("glitch_next");

      // Reset in the middle of the data bits
      send_frame(8'h77, 1'b1, 1'b0, -1, 4 * CPB);
      reset = 1'b1;
      uart_rx_input = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(2 * CPB);
      check_state("midrst");
      rx_byte(8'h12);
      check_state("midrst_next");
      pop_check("midrst_pop");

`ifdef UART_RX_PARITY_EN
      rx_byte(8'h03);
      check_state("par_ok");
      send_frame(8'h03, 1'b1, 1'b1, -1, FRAME_CYC);
      model_frame(8'h03, 1'b1, 1'b1, 1'b0);
      check_state("par_bad");
      pop_check("par_pop");
      clear_errors();
      check_state("par_clr");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receive front-end feeding the MCU's uart_rx_input path. It deserialises 8N1 frames from the asynchronous RX pin into bytes and buffers them in a small show-ahead FIFO that the core-side peripheral pops. Sticky error flags report framing errors and overruns to the core.

Parameters:
CLKS_PER_BIT, 217, clock cycles per bit (25 MHz / 115200); must be ≥ 8
FIFO_DEPTH, 8, FIFO entries; power of 2, ≥ 2

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
uart_rx_input  input  1  asynchronous serial line, idle high
rd_en  input  1  pop request; honoured only when rd_valid=1
rd_data  output  8  FIFO head byte; valid while rd_valid=1
rd_valid  output  1  FIFO not empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
frame_error  output  1  sticky; stop bit sampled low
overrun_error  output  1  sticky; byte received while FIFO full and no pop
err_clear  input  1  clears both sticky flags

Behaviour:
- Interface decided: one clock `clock`; `reset` is synchronous and active-high.
- Reset (one clocked reset cycle):
  - FSM→IDLE; 2-flop synchroniser and edge reg preset to 1.
  - FIFO empty: rd_valid=0, fifo_count=0, rd_data=0.
  - frame_error=0, overrun_error=0.
  - Reset mid-frame abandons the frame; no partial byte is pushed.
- Input: uart_rx_input passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s.
- FSM states IDLE, START, DATA, STOP, WAIT_IDLE. One bit counter (0..CLKS_PER_BIT-1) and a 3-bit data index.
  - IDLE: falling edge of rx_s (prev 1, now 0) → START, counter cleared.
  - START: at counter = CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
    - 1 → IDLE (glitch rejected, nothing recorded).
    - 0 → DATA, counter cleared.
  - DATA: sample at every counter = CLKS_PER_BIT-1. LSB first into a shift register. After the 8th sample → STOP.
  - STOP: sample at counter = CLKS_PER_BIT-1 (mid stop bit).
    - 1 → push byte, → IDLE.
    - 0 → frame_error set, byte discarded, → WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then → IDLE. A break condition (line held low) produces exactly one frame_error.
- Push latency: byte is written on the mid-stop sample clock; rd_valid/rd_data update the next cycle.
- FIFO: show-ahead; rd_data always reflects the head.
  - Pop on rd_en & rd_valid; the new head is visible the next cycle.
  - rd_en while empty is ignored, with no error.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count reaches FIFO_DEPTH when full.
  - Push and pop in the same cycle: both occur, count unchanged. If the FIFO is full, no overrun is flagged in that case.
  - Push while full with no pop: byte dropped, overrun_error set, FIFO contents untouched.
- Sticky flags: err_clear clears both. If a set event and err_clear occur in the same cycle, set wins.

Optional Feature:
UART_RX_PARITY_EN — when defined:
- A PARITY state is inserted between DATA and STOP; it samples one even-parity bit at counter = CLKS_PER_BIT-1.
- Adds output port `parity_error` (1, sticky, cleared by err_clear, set wins).
- On mismatch: byte not pushed, parity_error set; the stop bit is still checked (frame_error as above).

When undefined: no PARITY state, no parity_error port, strict 8N1.

Test Plan:
- CLKS_PER_BIT=16; reset held 2 cycles → all outputs 0, rd_valid=0, fifo_count=0. Send 0xA5 8N1 → rd_valid rises 1 cycle after mid-stop sample, rd_data=0xA5, fifo_count=1. Pulse rd_en → fifo_count=0, rd_valid=0.
- Send 0x00, 0xFF, 0x5A, 0x3C back-to-back with no pops → fifo_count=4, popped in order 0x00, 0xFF, 0x5A, 0x3C. Pointer wrap: 12 bytes in/out, interleaved in groups of 6, are read back with all values intact.
- Fill 8 bytes (0x01..0x08), send 0x09 with no pop → overrun_error=1, fifo_count=8, head still 0x01. Repeat with rd_en asserted on the push cycle → overrun_error stays 0 after err_clear, tail=0x09.
- Frame 0x55 with stop bit low, then line held low 40 bit-times → exactly one frame_error, fifo_count=0. Line returns high, send 0x33 → pushed normally. err_clear → frame_error=0.
- 5-cycle low glitch on idle line → no push, no error, FSM back to IDLE. Assert reset mid-DATA of 0x77 → no push, flags 0, next frame 0x12 received correctly.
- UART_RX_PARITY_EN defined: 0x03 with parity 0 → pushed. 0x03 with parity 1 → parity_error=1, not pushed, fifo_count unchanged.
